// File: rtl/screen_pkg.sv
// screen_pkg: shared screen ids, fade FSM encoding and default parameters for the compositor
package screen_pkg;

    localparam int unsigned SCR_TITLE = 0;
    localparam int unsigned SCR_GAME  = 1;
    localparam int unsigned SCR_INBET = 2;
    localparam int unsigned SCR_WIN   = 3;
    localparam int unsigned SCR_GOVER = 4;

    localparam int unsigned NUM_SCREENS_DEF    = 5;
    localparam int unsigned CL_W_DEF           = 5;
    localparam int unsigned MODE_W_DEF         = 3;
    localparam int unsigned FADE_SHIFT_DEF     = 4;
    localparam int unsigned DEFAULT_SCREEN_DEF = SCR_TITLE;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_e;

endpackage

// File: rtl/color_decode.sv
// color_decode: logical colour index to RGB565
// Ports: cl_i logical colour in; r_o/g_o/b_o RGB565 components out (combinational).
// Indices 0..7 are fixed primaries; 8 and above form a grey ramp.
module color_decode
    import screen_pkg::*;
#(
    parameter int unsigned CL_W = CL_W_DEF
) (
    input  logic [CL_W-1:0] cl_i,
    output logic [4:0]      r_o,
    output logic [5:0]      g_o,
    output logic [4:0]      b_o
);
    logic [4:0] v;
    assign v = 5'(cl_i);
    always_comb begin
        {r_o, g_o, b_o} = {v, v, v[4], v};
        case (v)
            5'd0: {r_o, g_o, b_o} = 16'h0000;
            5'd1: {r_o, g_o, b_o} = 16'hFFFF;
            5'd2: {r_o, g_o, b_o} = 16'hF800;
            5'd3: {r_o, g_o, b_o} = 16'h07E0;
            5'd4: {r_o, g_o, b_o} = 16'h001F;
            5'd5: {r_o, g_o, b_o} = 16'hFFE0;
            5'd6: {r_o, g_o, b_o} = 16'h07FF;
            5'd7: {r_o, g_o, b_o} = 16'hF81F;
            default: ;
        endcase
    end
endmodule

// File: rtl/screen_fade_scaler.sv
// screen_fade_scaler: combinational RGB565 brightness scaling, c_out = (c * level) >> FADE_SHIFT
// Ports: r_i/g_i/b_i colour in; level_i 0..2**FADE_SHIFT; r_o/g_o/b_o scaled colour out.
module screen_fade_scaler
    import screen_pkg::*;
#(
    parameter int unsigned FADE_SHIFT = FADE_SHIFT_DEF
) (
    input  logic [4:0]          r_i,
    input  logic [5:0]          g_i,
    input  logic [4:0]          b_i,
    input  logic [FADE_SHIFT:0] level_i,
    output logic [4:0]          r_o,
    output logic [5:0]          g_o,
    output logic [4:0]          b_o
);
    localparam int unsigned RBW = 5 + FADE_SHIFT + 1;
    localparam int unsigned GW  = 6 + FADE_SHIFT + 1;

    logic [RBW-1:0] r_p, b_p;
    logic [GW-1:0]  g_p;

    assign r_p = RBW'(r_i) * RBW'(level_i);
    assign g_p = GW'(g_i) * GW'(level_i);
    assign b_p = RBW'(b_i) * RBW'(level_i);
    assign r_o = 5'(r_p >> FADE_SHIFT);
    assign g_o = 6'(g_p >> FADE_SHIFT);
    assign b_o = 5'(b_p >> FADE_SHIFT);
endmodule

// File: rtl/vga_screen_compositor.sv
// vga_screen_compositor: selects one of NUM_SCREENS colour streams, decodes to RGB565, registers it
// Ports: clk, rst (async, active-high); mode_req requested screen; frame_start frame pulse;
//        video_on active-video qualifier; cl_in packed logical colours (screen i at [i*CL_W +: CL_W]);
//        active_mode routed screen; busy fade in progress; vga_r/vga_g/vga_b registered RGB565.
// Build option: define SCREEN_FADE_EN for fade-out/fade-in on screen changes; otherwise hard cut.
module vga_screen_compositor
    import screen_pkg::*;
#(
    parameter int unsigned NUM_SCREENS    = NUM_SCREENS_DEF,
    parameter int unsigned CL_W           = CL_W_DEF,
    parameter int unsigned MODE_W         = MODE_W_DEF,
    parameter int unsigned FADE_SHIFT     = FADE_SHIFT_DEF,
    parameter int unsigned DEFAULT_SCREEN = DEFAULT_SCREEN_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MODE_W-1:0]         mode_req,
    input  logic                      frame_start,
    input  logic                      video_on,
    input  logic [NUM_SCREENS*CL_W-1:0] cl_in,
    output logic [MODE_W-1:0]         active_mode,
    output logic                      busy,
    output logic [4:0]                vga_r,
    output logic [5:0]                vga_g,
    output logic [4:0]                vga_b
);
    if (NUM_SCREENS > (1 << MODE_W) || FADE_SHIFT == 0) begin : g_bad_params
        $error("vga_screen_compositor: MODE_W too narrow or FADE_SHIFT zero");
    end

    localparam logic [MODE_W-1:0] DEF_MODE = MODE_W'(DEFAULT_SCREEN);

    logic [MODE_W-1:0] req, active_mode_q;
    logic [CL_W-1:0]   cl_sel;
    logic [4:0]        dec_r, dec_b, pix_r, pix_b, vga_r_q, vga_b_q;
    logic [5:0]        dec_g, pix_g, vga_g_q;

    // Out-of-range requests fall back to the title screen.
    assign req = (32'(mode_req) < NUM_SCREENS) ? mode_req : '0;

    always_comb begin
        cl_sel = '0;
        for (int i = 0; i < NUM_SCREENS; i++)
            if (32'(active_mode_q) == i) cl_sel = cl_in[i*CL_W +: CL_W];
    end

    color_decode #(.CL_W(CL_W)) u_decode (
        .cl_i (cl_sel),
        .r_o  (dec_r),
        .g_o  (dec_g),
        .b_o  (dec_b)
    );

`ifdef SCREEN_FADE_EN
    localparam int unsigned LW = FADE_SHIFT + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(1 << FADE_SHIFT);

    fade_state_e       state_q;
    logic [LW-1:0]     level_q;
    logic [MODE_W-1:0] pending_q;

    // All fade state advances once per frame so brightness is constant within a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FADE_IN;
            level_q       <= '0;
            pending_q     <= DEF_MODE;
            active_mode_q <= DEF_MODE;
        end else if (frame_start) begin
            case (state_q)
                SHOW: begin
                    if (req != active_mode_q) begin
                        pending_q <= req;
                        state_q   <= FADE_OUT;
                    end
                end
                FADE_OUT: begin
                    pending_q <= req;
                    if (req == active_mode_q) begin
                        // Request withdrawn: climb back from the current level.
                        state_q <= FADE_IN;
                    end else begin
                        level_q <= level_q - LW'(1);
                        // Switch on the frame that reaches black so the cut is invisible.
                        if (level_q <= LW'(1)) begin
                            active_mode_q <= pending_q;
                            state_q       <= FADE_IN;
                        end
                    end
                end
                default: begin
                    // Saturates so a withdrawal at full level still lands cleanly in SHOW.
                    level_q <= (level_q >= LVL_FULL - LW'(1)) ? LVL_FULL : level_q + LW'(1);
                    if (level_q >= LVL_FULL - LW'(1)) state_q <= SHOW;
                end
            endcase
        end
    end

    assign busy = (state_q != SHOW);

    screen_fade_scaler #(.FADE_SHIFT(FADE_SHIFT)) u_scaler (
        .r_i     (dec_r),
        .g_i     (dec_g),
        .b_i     (dec_b),
        .level_i (level_q),
        .r_o     (pix_r),
        .g_o     (pix_g),
        .b_o     (pix_b)
    );
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) active_mode_q <= DEF_MODE;
        else if (frame_start) active_mode_q <= req;
    end

    assign busy  = 1'b0;
    assign pix_r = dec_r;
    assign pix_g = dec_g;
    assign pix_b = dec_b;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_r_q <= '0;
            vga_g_q <= '0;
            vga_b_q <= '0;
        end else begin
            vga_r_q <= video_on ? pix_r : '0;
            vga_g_q <= video_on ? pix_g : '0;
            vga_b_q <= video_on ? pix_b : '0;
        end
    end

    assign active_mode = active_mode_q;
    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;
endmodule

// File: tb/tb_vga_screen_compositor.sv
// tb_vga_screen_compositor: directed self-checking bench for vga_screen_compositor
module tb_vga_screen_compositor;
    localparam int NS = 5;
    localparam int CW = 5;
    localparam int MW = 3;
    localparam int FS = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic              video_on = 1'b1;
    logic [MW-1:0]     mode_req = '0;
    logic [NS*CW-1:0]  cl_in = '0;
    logic [MW-1:0]     active_mode;
    logic              busy;
    logic [4:0]        vga_r, vga_b;
    logic [5:0]        vga_g;
    int                n_tests = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;

    vga_screen_compositor #(
        .NUM_SCREENS    (NS),
        .CL_W           (CW),
        .MODE_W         (MW),
        .FADE_SHIFT     (FS),
        .DEFAULT_SCREEN (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_req    (mode_req),
        .frame_start (frame_start),
        .video_on    (video_on),
        .cl_in       (cl_in),
        .active_mode (active_mode),
        .busy        (busy),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame boundary, then one more pixel so the output reflects the new frame state.
    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] rgb();
        return {16'h0, vga_r, vga_g, vga_b};
    endfunction

    function automatic int sc(input int c, input int l);
        return (c * l) >> FS;
    endfunction

    // Screen colours: 0=red(2) 1=yellow(5) 2=grey20 3=green(3) 4=grey9.
    // Hand-decoded RGB565: F800, FFE0, A534, 07E0, 4A49.
    initial begin
        cl_in = {5'd9, 5'd3, 5'd20, 5'd5, 5'd2};
        mode_req = 3'd1;
        tick(2);
        check("rst_mode", active_mode, 0);
        check("rst_rgb", rgb(), 0);
`ifdef SCREEN_FADE_EN
        check("rst_busy", busy, 1);
        mode_req = 3'd0;
        rst = 1'b0;
        tick();
        check("lvl0_rgb", rgb(), 0);
        for (int k = 1; k <= 16; k++) begin
            frame();
            check("pwrup_r", vga_r, sc(31, k));
            check("pwrup_busy", busy, k < 16);
        end
        check("pwrup_full", rgb(), 32'hF800);
        mode_req = 3'd2;
        frame();
        check("fo_enter_busy", busy, 1);
        check("fo_enter_r", vga_r, 31);
        for (int k = 15; k >= 0; k--) begin
            frame();
            check("fo_r", vga_r, sc(31, k));
            check("fo_mode", active_mode, (k == 0) ? 2 : 0);
        end
        for (int k = 1; k <= 16; k++) begin
            frame();
            check("fi_r", vga_r, sc(20, k));
            check("fi_busy", busy, k < 16);
        end
        check("fi_full", rgb(), 32'hA534);
        mode_req = 3'd0;
        frame();
        repeat (5) frame();
        check("rev_lvl11", vga_r, sc(20, 11));
        mode_req = 3'd2;
        frame();
        check("rev_hold", vga_r, sc(20, 11));
        check("rev_mode", active_mode, 2);
        repeat (4) frame();
        check("rev_busy15", busy, 1);
        frame();
        check("rev_done_busy", busy, 0);
        check("rev_done_rgb", rgb(), 32'hA534);
        check("rev_done_mode", active_mode, 2);
        mode_req = 3'd0;
        frame();
        frame();
        #2 rst = 1'b1;
        #1;
        check("midrst_mode", active_mode, 0);
        check("midrst_rgb", rgb(), 0);
        check("midrst_busy", busy, 1);
        tick();
        rst = 1'b0;
`else
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check("show0", rgb(), 32'hF800);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("cut_mode", active_mode, 1);
        check("latency_old", rgb(), 32'hF800);
        tick();
        check("cut_rgb", rgb(), 32'hFFE0);
        check("busy_low", busy, 0);
        mode_req = 3'd2;
        tick(3);
        check("hold_mode", active_mode, 1);
        check("hold_rgb", rgb(), 32'hFFE0);
        frame();
        check("scr2_mode", active_mode, 2);
        check("scr2_rgb", rgb(), 32'hA534);
        mode_req = 3'd7;
        frame();
        check("oor7_mode", active_mode, 0);
        check("oor7_rgb", rgb(), 32'hF800);
        mode_req = 3'd4;
        frame();
        check("scr4_mode", active_mode, 4);
        check("scr4_rgb", rgb(), 32'h4A49);
        mode_req = 3'd5;
        frame();
        check("oor5_mode", active_mode, 0);
        video_on = 1'b0;
        tick();
        check("blank_rgb", rgb(), 0);
        video_on = 1'b1;
        tick();
        check("unblank_rgb", rgb(), 32'hF800);
        cl_in[4:0] = 5'd1;
        tick();
        check("pix_follow", rgb(), 32'hFFFF);
        mode_req = 3'd3;
        frame();
        check("scr3_mode", active_mode, 3);
        check("scr3_rgb", rgb(), 32'h07E0);
        #2 rst = 1'b1;
        #1;
        check("midrst_mode", active_mode, 0);
        check("midrst_rgb", rgb(), 0);
        check("midrst_busy", busy, 0);
        frame_start = 1'b1;
        tick();
        check("rst_wins", active_mode, 0);
        frame_start = 1'b0;
        rst = 1'b0;
        tick();
        check("post_rst_rgb", rgb(), 32'hFFFF);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
